// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int          c_drain_cycles_default = 4;
    localparam int          c_drain_cnt_w          = 4;
    localparam logic [4:0]  c_reg_x0               = 5'd0;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Flags an ID-stage read of a register a load in EX will write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign w_rs1_hit = (ex_rd == id_rs1);
    assign w_rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);
    assign load_use  = ex_memread & (ex_rd != c_reg_x0) & (w_rs1_hit | w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use stall, redirect flush and ECALL drain/halt control.
//               Optional MUL/DIV hold input when HAZARD_MDU_STALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = c_drain_cycles_default,
    parameter int STALL_CNT_W  = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_memread,
    input  logic                   ex_redirect,
    input  logic                   id_exit,
`ifdef HAZARD_MDU_STALL_EN
    input  logic                   mdu_busy,
`endif
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   ex_hold,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [c_drain_cnt_w-1:0] c_drain_load = c_drain_cnt_w'(DRAIN_CYCLES - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [c_drain_cnt_w-1:0] r_drain_cnt;
    logic [c_drain_cnt_w-1:0] w_drain_nxt;
    logic [STALL_CNT_W-1:0]   r_stall_cnt;
    logic                     r_halted;

    logic w_load_use;
    logic w_mdu_busy;
    logic w_hold;
    logic w_stall;
    logic w_redirect;
    logic w_exit_go;

    load_use_detect u_load_use_detect (
        .ex_memread  (ex_memread),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (w_load_use)
    );

`ifdef HAZARD_MDU_STALL_EN
    assign w_mdu_busy = mdu_busy;
`else
    assign w_mdu_busy = 1'b0;
`endif

    // A busy multi-cycle unit outranks every other event; once halted it is irrelevant
    assign w_hold     = w_mdu_busy & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_redirect = (r_state == ST_RUN) & ex_redirect & ~w_hold;
    assign w_stall    = (r_state == ST_RUN) & w_load_use & ~ex_redirect & ~w_hold;
    assign w_exit_go  = (r_state == ST_RUN) & id_exit & ~w_load_use & ~ex_redirect & ~w_hold;

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_halted    <= (w_state_nxt == ST_HALT);
            if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_exit_go) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = c_drain_load;
                end
            end
            ST_DRAIN: begin
                if (!w_hold) begin
                    if (r_drain_cnt == '0) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_drain_nxt = r_drain_cnt - 1'b1;
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_drain_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode; reset forces the RUN no-event values regardless of inputs
    // ------------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        if (rst_n) begin
            if (w_hold) begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                ex_hold = 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_redirect) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (w_stall) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        ifid_flush = 1'b1;
                    end
                    ST_HALT: begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end
                    default: begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                endcase
            end
        end
    end

    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed scoreboard bench for hazard_ctrl (DRAIN_CYCLES=4,
//               STALL_CNT_W=4). Extra MDU vectors when HAZARD_MDU_STALL_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    // expected flag vectors: {pc_en, ifid_en, ifid_flush, idex_flush, ex_hold, halted}
    localparam logic [5:0] c_run   = 6'b110000;
    localparam logic [5:0] c_stall = 6'b000100;
    localparam logic [5:0] c_redir = 6'b111100;
    localparam logic [5:0] c_drain = 6'b001000;
    localparam logic [5:0] c_halt  = 6'b001101;
    localparam logic [5:0] c_hold  = 6'b000010;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic [4:0] id_rs2 = '0;
    logic       id_uses_rs2 = 1'b0;
    logic [4:0] ex_rd = '0;
    logic       ex_memread = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       id_exit = 1'b0;
    logic       mdu_busy = 1'b0;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, ex_hold, halted;
    logic [3:0] stall_cnt;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .DRAIN_CYCLES (4),
        .STALL_CNT_W  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_redirect (ex_redirect),
        .id_exit     (id_exit),
`ifdef HAZARD_MDU_STALL_EN
        .mdu_busy    (mdu_busy),
`endif
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .ex_hold     (ex_hold),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    // Drive one cycle of inputs just after the rising edge and queue the expectation
    task automatic step(input string nm, input logic rn, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic rdr, input logic ex, input logic mb,
                        input logic [5:0] flags, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rn;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_uses_rs2 = u2;
        ex_rd       = rd;
        ex_memread  = mr;
        ex_redirect = rdr;
        id_exit     = ex;
        mdu_busy    = mb;
        e.name = nm;
        e.exp  = {flags, cnt[3:0]};
        sbq.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [5:0] flags, input int cnt);
        step(nm, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, flags, cnt);
    endtask

    // Monitor: compare on the falling edge, away from the register update
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t       e;
            logic [9:0] got;
            e   = sbq.pop_front();
            got = {pc_en, ifid_en, ifid_flush, idex_flush, ex_hold, halted, stall_cnt};
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s got=%b required=%b (pc,ifid,iff,idf,hold,halted,cnt)",
                         e.name, got, e.exp);
            end
        end
    end

    initial begin
        step("reset_outputs", 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_run, 0);
        idle("after_release", c_run, 0);
        step("load_use_rs1", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_stall, 0);
        idle("stall_cnt_one", c_run, 1);
        step("rd_x0_no_stall", 1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, c_run, 1);
        step("rs2_unused", 1'b1, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, c_run, 1);
        step("load_use_rs2", 1'b1, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, c_stall, 1);
        step("redirect_wins", 1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, c_redir, 2);
        idle("still_run", c_run, 2);
        step("exit_deferred", 1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, c_stall, 2);
        step("exit_accept", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, c_run, 3);
        step("drain_1", 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, c_drain, 3);
        idle("drain_2", c_drain, 3);
        idle("drain_3", c_drain, 3);
        idle("drain_4", c_drain, 3);
        idle("halt", c_halt, 3);
        step("halt_held", 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, c_halt, 3);
        step("reset_in_halt", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, c_run, 0);
        idle("run_after_halt", c_run, 0);
        step("exit_again", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, c_run, 0);
        idle("drain_a1", c_drain, 0);
        step("reset_mid_drain", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, c_run, 0);
        idle("run_post_drain", c_run, 0);
        idle("no_resume_drain", c_run, 0);
        for (int i = 0; i < 20; i++) begin
            step("saturate", 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0,
                 c_stall, (i > 15) ? 15 : i);
        end
        idle("saturated_hold", c_run, 15);
`ifdef HAZARD_MDU_STALL_EN
        step("mdu_reset", 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, c_run, 0);
        step("mdu_beats_redir", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, c_hold, 0);
        step("mdu_exit", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, c_run, 0);
        idle("mdu_drain_1", c_drain, 0);
        for (int i = 0; i < 3; i++) begin
            step("mdu_hold_drain", 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, c_hold, 0);
        end
        idle("mdu_drain_2", c_drain, 0);
        idle("mdu_drain_3", c_drain, 0);
        idle("mdu_drain_4", c_drain, 0);
        idle("mdu_halt", c_halt, 0);
`endif
        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, cycles of pipeline drain between ECALL acceptance and halt (legal 1..15).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of the load-use stall counter.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_rs1  in  5  rs1 index of the instruction in ID.
REQ-006 SHALL have port id_rs2  in  5  rs2 index of the instruction in ID.
REQ-007 SHALL have port id_uses_rs2  in  1  the ID instruction reads rs2 (R, S, B types).
REQ-008 SHALL have port ex_rd  in  5  destination index of the instruction in EX.
REQ-009 SHALL have port ex_memread  in  1  the EX instruction is a load.
REQ-010 SHALL have port ex_redirect  in  1  a taken branch, JAL or JALR resolved in EX.
REQ-011 SHALL have port id_exit  in  1  ECALL decoded in ID.
REQ-012 SHALL have port pc_en  out  1  PC register update enable.
REQ-013 SHALL have port ifid_en  out  1  IF/ID register load enable.
REQ-014 SHALL have port ifid_flush  out  1  inject a bubble into IF/ID.
REQ-015 SHALL have port idex_flush  out  1  inject a bubble into ID/EX.
REQ-016 SHALL have port ex_hold  out  1  freeze ID/EX and EX/MEM (0 when the REQ-030 macro is undefined).
REQ-017 SHALL have port halted  out  1  registered; core has retired ECALL and stopped.
REQ-018 SHALL have port stall_cnt  out  STALL_CNT_W  saturating count of load-use stall cycles.

Function
REQ-019 SHALL implement a 3-state FSM: RUN, DRAIN, HALT.
REQ-020 In RUN, load_use = ex_memread & (ex_rd!=0) & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)); when asserted: pc_en=0, ifid_en=0, idex_flush=1 in the same cycle (combinational, zero latency).
REQ-021 In RUN, ex_redirect SHALL drive ifid_flush=1 and idex_flush=1 with pc_en=1; redirect overrides load_use (no stall that cycle).
REQ-022 In RUN, id_exit with no load_use and no ex_redirect SHALL move to DRAIN next cycle and load the drain counter with DRAIN_CYCLES-1; id_exit during ex_redirect is wrong-path and SHALL be ignored; during load_use it is deferred until the stall clears.
REQ-023 In DRAIN: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=0; counter decrements each cycle; at 0 transition to HALT.
REQ-024 In HALT: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, halted=1 registered; HALT exits only via reset.
REQ-025 In RUN with no event: pc_en=1, ifid_en=1, all flushes 0.
REQ-026 stall_cnt SHALL increment by 1 each cycle load_use stalls the pipeline and saturate at all-ones.

Reset
REQ-027 rst_n low SHALL immediately force state=RUN, drain counter=0, stall_cnt=0, halted=0.
REQ-028 Reset mid-DRAIN or in HALT SHALL abort drain; first cycle after release behaves as RUN.
REQ-029 Combinational outputs during reset SHALL equal RUN no-event values (pc_en=1, ifid_en=1, flushes 0, ex_hold=0).

Configuration
REQ-030 Macro HAZARD_MDU_STALL_EN defined: adds input mdu_busy (1 bit, multi-cycle MUL/DIV in EX); while mdu_busy in RUN or DRAIN: ex_hold=1, pc_en=0, ifid_en=0, flushes 0, drain counter frozen, FSM holds state, mdu_busy beats redirect and load_use.
REQ-031 Macro undefined: no mdu_busy port, ex_hold tied 0, no other behaviour change.

Structure
REQ-032 Package hazard_pkg SHALL hold the FSM state enum, DRAIN_CYCLES default and the register-x0 index constant.
REQ-033 Sub-module load_use_detect SHALL contain the REQ-020 comparison; the FSM, counters and output muxing stay in hazard_ctrl.

Verification
REQ-034 ex_memread=1, ex_rd=5, id_rs1=5 -> same cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-035 ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall.
REQ-036 ex_redirect=1 with load_use and id_exit true -> ifid_flush=1, idex_flush=1, pc_en=1, state stays RUN, stall_cnt unchanged.
REQ-037 id_exit=1 in RUN, DRAIN_CYCLES=4 -> 4 cycles DRAIN with pc_en=0, then halted=1 and held; rst_n low mid-DRAIN -> halted=0, pc_en=1 immediately.
REQ-038 STALL_CNT_W=4, 20 consecutive load-use cycles -> stall_cnt saturates at 15.
REQ-039 With HAZARD_MDU_STALL_EN, mdu_busy=1 for 3 cycles during DRAIN -> ex_hold=1, drain extended by exactly 3 cycles.
